ext_reg_slv: RTL

Responder end of the register-native request/ack protocol: a parameterized bank of external registers driven by the slave side of the register-access FSM. It accepts one read or write per `req_vld`/`req_rdy` handshake and returns read data with a programmable response latency on `ack_vld`/`ack_rdy`. It also exposes the register contents to hardware. It is the standard endpoint for testing and for simple external register blocks hung off the FSM.

---
 rtl/ext_reg_slv_pkg.sv | 27 ++
 rtl/ext_reg_slv_decode.sv | 40 ++++
 rtl/ext_reg_slv.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ext_reg_slv_pkg.sv
// -----------------------------------------------------------------------------
// ext_reg_slv_pkg
// Shared types and constants for the external register responder.
//   ext_slv_state_e : responder FSM state encoding
//   ERR_PATTERN     : read data returned for an errored access when the
//                     address-error option is built in
//   LAT_W           : width of the response-latency counter
//   idx_width()     : register-index width for a bank of n registers
// -----------------------------------------------------------------------------
package ext_reg_slv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } ext_slv_state_e;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  localparam int LAT_W = 4;

  // A single-register bank still needs a 1-bit index to keep port widths legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_reg_slv_decode.sv
// -----------------------------------------------------------------------------
// ext_reg_slv_decode
// Combinational byte-address to register-index decoder.
//   addr_i : request byte address
//   hit_o  : address is at/after BASE_ADDR, word aligned and inside the bank
//   idx_o  : register index, meaningful only when hit_o is high
// -----------------------------------------------------------------------------
module ext_reg_slv_decode
  import ext_reg_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUM    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  output logic                           hit_o,
  output logic [idx_width(REG_NUM)-1:0]  idx_o
);

  localparam int                    IDX_W     = idx_width(REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] BYTES_A   = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] REG_NUM_A = ADDR_WIDTH'(REG_NUM);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;

  // Constant divisor: reduces to a shift/mask for power-of-two byte widths.
  always_comb begin
    off      = addr_i - BASE_ADDR;
    idx_full = off / BYTES_A;
    // The lower-bound test matters: below BASE_ADDR the subtraction wraps and
    // could otherwise alias onto a valid index.
    hit_o    = (addr_i >= BASE_ADDR) &&
               ((off % BYTES_A) == '0) &&
               (idx_full < REG_NUM_A);
    idx_o    = idx_full[IDX_W-1:0];
  end

endmodule

// File: rtl/ext_reg_slv.sv
// -----------------------------------------------------------------------------
// ext_reg_slv
// Responder end of the register request/ack protocol: a bank of REG_NUM
// registers, one access per req handshake, response after ACK_LATENCY wait
// cycles, register contents exported flat on reg_q.
//
// Ports
//   clk, rstn                 : clock, asynchronous active-low reset
//   fsm__slv__sync_reset      : synchronous soft reset (same effect as rstn)
//   fsm__slv__req_vld / slv__fsm__req_rdy : request handshake
//   fsm__slv__addr, _wr_en, _rd_en, _wr_data : request payload
//   slv__fsm__ack_vld / fsm__slv__ack_rdy : response handshake
//   slv__fsm__rd_data         : response data, zero while ack_vld is low
//   slv__fsm__err             : only with EXT_REG_SLV_ADDR_ERR_EN defined;
//                               flags a miss or a no-op request
//   reg_q                     : register i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Build option: define EXT_REG_SLV_ADDR_ERR_EN to add slv__fsm__err and return
// ERR_PATTERN as data on errored accesses.
// -----------------------------------------------------------------------------
module ext_reg_slv
  import ext_reg_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    REG_NUM     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    ACK_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          fsm__slv__sync_reset,
  input  logic                          fsm__slv__req_vld,
  output logic                          slv__fsm__req_rdy,
  input  logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
  input  logic                          fsm__slv__wr_en,
  input  logic                          fsm__slv__rd_en,
  input  logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
  output logic                          slv__fsm__ack_vld,
  input  logic                          fsm__slv__ack_rdy,
  output logic [DATA_WIDTH-1:0]         slv__fsm__rd_data,
`ifdef EXT_REG_SLV_ADDR_ERR_EN
  output logic                          slv__fsm__err,
`endif
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
);

  localparam int               IDX_W    = idx_width(REG_NUM);
  localparam logic [LAT_W-1:0] LAT_INIT = (ACK_LATENCY > 0) ? LAT_W'(ACK_LATENCY - 1) : '0;

  ext_slv_state_e state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  // Held low through reset so req_rdy reads 0 while rstn is asserted.
  logic live_q;

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] bank_q, bank_d;
  logic [DATA_WIDTH-1:0]              cap_q, cap_d;

`ifdef EXT_REG_SLV_ADDR_ERR_EN
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_PATTERN);
  logic err_q, err_d;
  logic is_err;
`endif

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             accept;

  ext_reg_slv_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .addr_i (fsm__slv__addr),
    .hit_o  (hit),
    .idx_o  (idx)
  );

  assign accept = fsm__slv__req_vld & slv__fsm__req_rdy;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ACK_LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACK: begin
        if (fsm__slv__ack_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fsm__slv__sync_reset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state. sync_reset gates req_rdy so a
  // request presented alongside a soft reset is visibly refused, not dropped
  // after a handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    slv__fsm__req_rdy = live_q && (state_q == S_IDLE) && !fsm__slv__sync_reset;
    slv__fsm__ack_vld = (state_q == S_ACK);
    slv__fsm__rd_data = (state_q == S_ACK) ? cap_q : '0;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
    slv__fsm__err     = (state_q == S_ACK) && err_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath: register bank and response capture
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_d = bank_q;
    cap_d  = cap_q;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
    err_d  = err_q;
    is_err = !hit || (!fsm__slv__wr_en && !fsm__slv__rd_en);
`endif
    if (accept) begin
      // Write wins over read when both enables are set.
      if (fsm__slv__wr_en && hit) bank_d[idx] = fsm__slv__wr_data;
      cap_d = (!fsm__slv__wr_en && fsm__slv__rd_en && hit) ? bank_q[idx] : '0;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
      err_d = is_err;
      if (is_err) cap_d = ERR_DATA;
`endif
    end
    if (fsm__slv__sync_reset) begin
      bank_d = '0;
      cap_d  = '0;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
      err_d  = 1'b0;
`endif
    end
  end

  // NOTE: the bank is reset because it is exported on reg_q as live hardware
  // state; a RAM-style bank left unreset would leak X into consumers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_q <= '0;
      cap_q  <= '0;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      bank_q <= bank_d;
      cap_q  <= cap_d;
`ifdef EXT_REG_SLV_ADDR_ERR_EN
      err_q  <= err_d;
`endif
    end
  end

  assign reg_q = bank_q;

endmodule
